// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared instruction-format constants, opcodes and sequencer
//               state encoding for the instruction path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int IW = 18;

  localparam int OPC_MSB = 17;
  localparam int OPC_LSB = 14;
  localparam int R1_MSB  = 13;
  localparam int R1_LSB  = 11;
  localparam int R2_MSB  = 10;
  localparam int R2_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_OR    = 4'h5;
  localparam logic [3:0] OP_XOR   = 4'h6;
  localparam logic [3:0] OP_STORE = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_FETCH  = 3'd1,
    SEQ_DECODE = 3'd2,
    SEQ_ISSUE  = 3'd3,
    SEQ_DONE   = 3'd4
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/instr_field_split.sv
// ============================================================================
// Module      : instr_field_split
// Description : Combinational split of one instruction word into opcode,
//               register IDs and immediate.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_field_split #(
  parameter int IW = 18
) (
  input  logic [IW-1:0] instr,
  output logic [3:0]    opcode,
  output logic [2:0]    reg1,
  output logic [2:0]    reg2,
  output logic [7:0]    imm
);
  import cpu_pkg::*;

  assign opcode = instr[OPC_MSB:OPC_LSB];
  assign reg1   = instr[R1_MSB:R1_LSB];
  assign reg2   = instr[R2_MSB:R2_LSB];
  assign imm    = instr[IMM_MSB:IMM_LSB];

endmodule

`default_nettype wire

// File: rtl/instruction_sequencer.sv
// ============================================================================
// Module      : instruction_sequencer
// Description : Steps a PC through stored instructions, decodes each word and
//               issues it over a valid/ready handshake. Build option
//               SEQ_LOOP_EN repeats the program instead of finishing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_sequencer #(
  parameter int DEPTH = 10,
  parameter int IW    = 18
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          run,
  input  logic          stop,
  input  logic [3:0]    instr_count,
  input  logic [IW-1:0] mem_rdata,
  output logic [3:0]    mem_addr,
  output logic [3:0]    opCode,
  output logic [2:0]    regID1,
  output logic [2:0]    regID2,
  output logic [7:0]    immValue,
  output logic          issue_valid,
  input  logic          issue_ready,
  output logic          busy,
  output logic          done
);
  import cpu_pkg::*;

  localparam logic [3:0] C_DEPTH = 4'(DEPTH);

  seq_state_t    r_state;
  logic [3:0]    r_pc;
  logic [3:0]    r_eff;
  logic [IW-1:0] r_ir;
  logic          r_settle;

  logic [3:0]    w_eff;
  logic [3:0]    w_pc_next;
  logic [3:0]    w_opcode;
  logic [2:0]    w_reg1;
  logic [2:0]    w_reg2;
  logic [7:0]    w_imm;

  assign w_eff     = (instr_count > C_DEPTH) ? C_DEPTH : instr_count;
  assign w_pc_next = r_pc + 4'd1;
  assign mem_addr  = r_pc;

  instr_field_split #(
    .IW (IW)
  ) u_split (
    .instr  (r_ir),
    .opcode (w_opcode),
    .reg1   (w_reg1),
    .reg2   (w_reg2),
    .imm    (w_imm)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= SEQ_IDLE;
      r_pc        <= 4'd0;
      r_eff       <= 4'd0;
      r_ir        <= '0;
      r_settle    <= 1'b0;
      opCode      <= 4'd0;
      regID1      <= 3'd0;
      regID2      <= 3'd0;
      immValue    <= 8'd0;
      issue_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (stop) begin
      r_state     <= SEQ_IDLE;
      r_pc        <= 4'd0;
      r_eff       <= 4'd0;
      r_ir        <= '0;
      r_settle    <= 1'b0;
      opCode      <= 4'd0;
      regID1      <= 3'd0;
      regID2      <= 3'd0;
      immValue    <= 8'd0;
      issue_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        SEQ_IDLE: begin
          if (run) begin
            r_pc  <= 4'd0;
            r_eff <= w_eff;
            busy  <= 1'b1;
            if (w_eff == 4'd0) begin
              r_state  <= SEQ_DONE;
              r_settle <= 1'b1;
            end else begin
              r_state <= SEQ_FETCH;
            end
          end
        end
        SEQ_FETCH: begin
          r_ir    <= mem_rdata;
          r_state <= SEQ_DECODE;
        end
        SEQ_DECODE: begin
          opCode   <= w_opcode;
          regID1   <= w_reg1;
          regID2   <= w_reg2;
          immValue <= w_imm;
          if (w_opcode == OP_HALT) begin
            r_state  <= SEQ_DONE;
            r_settle <= 1'b1;
          end else begin
            r_state     <= SEQ_ISSUE;
            issue_valid <= 1'b1;
          end
        end
        SEQ_ISSUE: begin
          if (issue_ready) begin
            issue_valid <= 1'b0;
            if (w_pc_next == r_eff) begin
`ifdef SEQ_LOOP_EN
              r_pc    <= 4'd0;
              r_state <= SEQ_FETCH;
`else
              r_state <= SEQ_DONE;
              done    <= 1'b1;
`endif
            end else begin
              r_pc    <= w_pc_next;
              r_state <= SEQ_FETCH;
            end
          end
        end
        SEQ_DONE: begin
          // HALT and zero-count exits spend one settle cycle here before done pulses
          if (r_settle) begin
            r_settle <= 1'b0;
            done     <= 1'b1;
          end else begin
            r_state <= SEQ_IDLE;
            busy    <= 1'b0;
          end
        end
        default: r_state <= SEQ_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/instruction_sequencer.md
# instruction_sequencer

Downstream consumer of the instruction memory. On a `run` pulse it steps a program counter through the stored 18-bit instructions. Each word is split into opcode, register IDs and immediate, then issued to the execute stage over a valid/ready handshake. It stops at the programmed count or at a HALT opcode. It drives the read address of the memory-output mux and replaces the switch-driven path once a program has been entered.

## Interface
Parameters:
- `DEPTH`, 10, number of instruction slots addressable (max 15)
- `IW`, 18, instruction width; field layout fixed: [17:14] opcode, [13:11] regID1, [10:8] regID2, [7:0] immediate

Ports:
- `clock`  in  1  single clock; all state updates on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `run`  in  1  start request, sampled only in IDLE
- `stop`  in  1  synchronous abort, any state
- `instr_count`  in  4  number of valid stored instructions
- `mem_rdata`  in  IW  instruction at `mem_addr` (combinational mux, same cycle)
- `mem_addr`  out  4  read address = current PC
- `opCode`  out  4  decoded opcode
- `regID1`, `regID2`  out  3 each  decoded register IDs
- `immValue`  out  8  decoded immediate
- `issue_valid`  out  1  decoded fields valid for execute stage
- `issue_ready`  in  1  execute stage accepts
- `busy`  out  1  high in any state but IDLE
- `done`  out  1  one-cycle pulse at program end

## Operation
- States: IDLE, FETCH, DECODE, ISSUE, DONE.
- IDLE:
  - `run`=1 → PC←0, go to FETCH.
  - If effective count is 0, go to DONE instead.
  - Effective count = min(`instr_count`, DEPTH), latched at `run`.
- FETCH: IR←`mem_rdata`; go to DECODE.
- DECODE: output field registers ← IR slices.
  - opcode 4'hF (HALT) → DONE; HALT is never issued.
  - Otherwise → ISSUE.
- ISSUE: `issue_valid`=1. Fields are held stable until `issue_valid && issue_ready`.
  - On handshake, if PC+1 == effective count → DONE.
  - Otherwise PC←PC+1, go to FETCH.
- DONE: `done`=1 for one cycle, then IDLE.
- `stop` has priority over every other transition: next state is IDLE and `issue_valid` is cleared.
  - `stop` coincident with a handshake: the instruction counts as accepted; no further issue.
- `run` outside IDLE is ignored.
- `instr_count` changes after `run` have no effect until the next `run`.
- PC arithmetic is 4-bit unsigned. PC never exceeds effective count − 1, so there is no wrap without the loop option.

## Timing
- Reset values: state IDLE, PC 0, `mem_addr` 0, all decoded fields 0, `issue_valid` 0, `busy` 0, `done` 0.
- Reset mid-program: asynchronous return to these values immediately; no partial issue is completed.
- Latency from `run` sampled (cycle 0) to `issue_valid` high: cycle 3.
- Minimum issue interval: 3 cycles per instruction (FETCH, DECODE, ISSUE) with `issue_ready` held high.
- `issue_ready` low stalls in ISSUE indefinitely; fields do not change.
- `done` is asserted the cycle after the last handshake, or 2 cycles after the DECODE of a HALT.
- `busy` is registered and high from cycle 1 through the DONE cycle.

## Configuration
- Macro `SEQ_LOOP_EN`.
- Defined: reaching the effective count sets PC←0, returns to FETCH and does not pulse `done`; the program repeats until `stop` or HALT.
- Not defined: single pass ending in DONE, as above.
- A zero count goes to DONE in both builds.

## Structure
- Shared package `cpu_pkg` holds:
  - field position constants
  - opcode constants, including `OP_HALT` = 4'hF
  - the sequencer state enum
  - `IW`
- The instruction memory and fetcher move to the same package constants.
- One sub-module: `instr_field_split`, a pure combinational slice of IW bits into the four fields. It is also reusable by the entry-side fetcher.

## Test plan
- `instr_count`=3, memory {18'h04000, 18'h0A9FF, 18'h1C803}, `issue_ready`=1, `run` pulse → three issues at cycles 3, 6, 9 with opCode 1/2/7, immValue 00/FF/03; `done` at cycle 10.
- Same program with `issue_ready` low for 5 cycles during the 2nd issue → fields constant throughout the stall; `done` delayed 5 cycles.
- Word 1 = 18'h3C000 (HALT), count 3 → exactly one issue, then `done`; slot 2 never issued.
- `instr_count`=0 → `done` 2 cycles after `run`, no `issue_valid`. `instr_count`=12 → exactly 10 issues.
- `stop` during a stalled ISSUE, and `reset_n` low mid-FETCH → IDLE next cycle / immediately, all outputs at reset values, no `done`.
- With `SEQ_LOOP_EN`, count 2 → issue order 0,1,0,1… and no `done` until `stop`.
